// File: rtl/mem_pkg.sv
// Shared encodings for the byte-addressed data memory controller.
package mem_pkg;

  // Access size encodings carried on req_size
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  // Latency counter width; covers LATENCY up to 8
  localparam int LAT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the 32-bit memory word and the load/store port.
// Stores: byte enables plus lane-replicated write data.
// Loads: extract the addressed byte/half and sign- or zero-extend it.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [31:0] sh_b;
  logic [31:0] sh_h;
  logic [7:0]  b_sel;
  logic [15:0] h_sel;

  // Shift the addressed lane down to bit 0 for loads
  assign sh_b  = rword >> {addr_lo, 3'b000};
  assign sh_h  = rword >> {addr_lo[1], 4'b0000};
  assign b_sel = sh_b[7:0];
  assign h_sel = sh_h[15:0];

  // Decode enables and data per access size; illegal size touches nothing
  always_comb begin
    be         = 4'b0000;
    wdata_lane = wdata;
    rdata_ext  = '0;
    case (size)
      SIZE_B: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = uns ? {24'b0, b_sel} : {{24{b_sel[7]}}, b_sel};
      end
      SIZE_H: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = uns ? {16'b0, h_sel} : {{16{h_sel[15]}}, h_sel};
      end
      SIZE_W: begin
        be         = 4'b1111;
        rdata_ext  = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with valid/ready request and held response.
// One transaction outstanding; the memory update / read happens on the accept
// edge, the response appears LATENCY cycles later and waits for rsp_ready.
module data_memory_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t               state, state_nx;
  logic [LAT_CNT_W-1:0] cnt, cnt_nx;

  logic [31:0] mem [0:DEPTH-1];

  logic              accept;
  logic [ADDR_W-3:0] word_idx;
  logic [IDX_W-1:0]  idx;
  logic              err_size, err_align, err_range, req_err;
  logic [31:0]       rword;
  logic [3:0]        be;
  logic [31:0]       wdata_lane;
  logic [31:0]       rdata_ext;
  logic [31:0]       rdata_q;
  logic              err_q;

  assign accept   = req_valid && (state == IDLE);
  assign word_idx = req_addr[ADDR_W-1:2];

  // Any single failing check rejects the access; the priority order only
  // matters for diagnosis, as all three collapse onto one error bit.
  assign err_size  = (req_size == SIZE_X);
  assign err_align = ((req_size == SIZE_H) && req_addr[0]) ||
                     ((req_size == SIZE_W) && (req_addr[1:0] != 2'b00));
  // Full word index is compared so high address bits cannot alias low words
  assign err_range = (word_idx >= (ADDR_W-2)'(DEPTH));
  assign req_err   = err_size || err_align || err_range;

  // Truncated index is only used when the range check has passed
  assign idx   = word_idx[IDX_W-1:0];
  assign rword = mem[idx];

  mem_lane_align u_align (
    .addr_lo    (req_addr[1:0]),
    .size       (req_size),
    .uns        (req_unsigned),
    .wdata      (req_wdata),
    .rword      (rword),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext)
  );

  // Memory array: byte-lane writes committed on the accept edge, never reset
  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

  // Response payload captured at accept and held until the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      rdata_q <= (req_we || req_err) ? 32'h0 : rdata_ext;
      err_q   <= req_err;
    end
  end

  // State and latency counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state: WAIT spends LATENCY-1 cycles before RESP
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nx   = '0;
          state_nx = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == LAT_CNT_W'(LATENCY - 2)) state_nx = RESP;
        else                                cnt_nx   = cnt + 1'b1;
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
